// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency instruction memory
// and hands each word to the core over a valid/ready handshake, with redirect support.
module mips_ifetch #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [31:0]       ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       fetch_cnt
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic [DATA_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic                handshake;
    logic                unused_rpc_bits;

    // Word alignment discards the low byte-offset bits of the redirect target.
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign handshake = (state_q == S_VALID) && ir_ready;

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Next-state and datapath update; redirect overrides the normal flow
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_cnt_d = fetch_cnt_q + DATA_W'(handshake);

        case (state_q)
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ir_d       = imem_rdata;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + 32'd4;
                ir_valid_d = 1'b1;
                state_d    = S_VALID;
            end
            S_VALID: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (redirect) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            ir_d       = ir_q;
            ir_pc_d    = ir_pc_q;
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
        end
    end

    // Memory strobe: a fetch issues in FETCH or alongside an accepted handshake
    always_comb begin
        imem_en = 1'b0;
        if (!sys_rst && !redirect) begin
            imem_en = (state_q == S_FETCH) || handshake;
        end
    end

    assign imem_addr = pc_q[ADDR_W+1:2];
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/mips_ifetch.md
# mips_ifetch

Instruction-fetch stage of the multi-cycle MIPS core. It holds the program counter, reads 32-bit words from a synchronous instruction memory with a 1-cycle read latency, and presents each word as the instruction register (IR) to the decode/execute core. The transfer to the core uses a valid/ready handshake. The core can redirect fetch at any time for branches and jumps.

## Interface
- ADDR_W, 8: word-address width of the instruction memory; depth is 2^ADDR_W words.
- RESET_PC, 32'h0000_0000: byte address of the first instruction fetched after reset.
- sys_clk  in  1  clock; all logic is rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- imem_en  out  1  read strobe to the instruction memory.
- imem_addr  out  ADDR_W  word address; always equals pc[ADDR_W+1:2].
- imem_rdata  in  32  read data; valid in the cycle after imem_en=1.
- ir  out  32  current instruction word.
- ir_pc  out  32  byte address of the word in ir.
- ir_valid  out  1  ir and ir_pc hold an instruction not yet accepted.
- ir_ready  in  1  core accepts the instruction when ir_valid&ir_ready.
- redirect  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  target byte address; bits [1:0] are forced to 0.
- fetch_cnt  out  32  count of accepted handshakes; wraps at 2^32.

## Operation
- Internal registers: pc (32 bits), state ∈ {FETCH, WAIT, VALID}.
- FETCH:
  - imem_en=1, imem_addr=pc.
  - Next state: WAIT.
- WAIT: at the clock edge, all of the following happen, then next state is VALID:
  - ir<=imem_rdata
  - ir_pc<=pc
  - pc<=pc+4 (mod 2^32)
  - ir_valid<=1
- VALID:
  - ir_valid=1.
  - If ir_ready=1, the handshake completes:
    - imem_en=1 with imem_addr=pc, issuing the next fetch in the same cycle.
    - ir_valid<=0.
    - fetch_cnt<=fetch_cnt+1.
    - Next state: WAIT.
  - If ir_ready=0, stay in VALID. ir and ir_pc stay stable and imem_en=0.
- Redirect has priority over normal state flow in every state. At the edge where redirect=1:
  - pc<={redirect_pc[31:2],2'b00}
  - ir_valid<=0
  - state<=FETCH
  - Any read in flight (WAIT) is discarded and ir is not updated.
  - imem_en is forced to 0 during the redirect cycle.
- Redirect and handshake in the same cycle (VALID, ir_valid&ir_ready&redirect):
  - The handshake counts as accepted and fetch_cnt increments.
  - The next instruction fetched is from redirect_pc.
- Reset has priority over redirect. At an edge with sys_rst=1:
  - pc<=RESET_PC
  - ir<=0, ir_pc<=0, ir_valid<=0
  - fetch_cnt<=0
  - state<=FETCH
  - imem_en is 0 while sys_rst=1.
- Address wrap: pc+4 wraps at 2^32. imem_addr wraps naturally modulo 2^ADDR_W. No error is flagged.
- ir_valid never drops without a handshake, except on redirect or reset.

## Timing
- Reset values: imem_en=0, imem_addr=RESET_PC[ADDR_W+1:2], ir=0, ir_pc=0, ir_valid=0, fetch_cnt=0.
- Cycle 0 is the first cycle with sys_rst=0:
  - Cycle 0: FETCH, imem_en=1.
  - Cycle 1: WAIT, data returns.
  - Cycle 2: ir_valid=1.
- Steady state with ir_ready held at 1: one instruction every 2 cycles. ir_valid alternates 1,0; imem_en is high in each VALID cycle.
- Redirect in cycle N: FETCH in cycle N+1, and the target instruction is valid in cycle N+3.
- All outputs are registered except imem_en and imem_addr, which are decoded from state, pc, redirect and sys_rst.

## Test plan
- Reset/first fetch: imem word0=32'h2000_00C2, RESET_PC=0.
  - Release sys_rst.
  - Required: imem_en=1 and imem_addr=0 in cycle 0.
  - Required: ir=32'h2000_00C2, ir_pc=0, ir_valid=1 in cycle 2.
- Streaming: words 0..2 = 32'h2000_00C2, 32'h2000_0555, 32'h0020_0820; ir_ready=1 throughout.
  - Required: three handshakes in cycles 2, 4, 6 with ir_pc=0, 4, 8.
  - Required: fetch_cnt=3 afterwards.
- Backpressure: hold ir_ready=0 for 5 cycles while ir_valid=1.
  - Required: ir and ir_pc stable, imem_en=0, fetch_cnt unchanged.
  - Then ir_ready=1: the next word arrives 2 cycles later.
- Redirect during WAIT: redirect=1 with redirect_pc=32'h0000_0043.
  - Required: the discarded word never appears on ir.
  - Required: the next ir_pc=32'h40, and imem_addr=8'h10 on the FETCH cycle.
- Redirect coincident with handshake in VALID:
  - Required: fetch_cnt increments by 1 and ir_valid=0 next cycle.
  - Required: the following instruction comes from the target address.
- Reset mid-operation and wrap:
  - sys_rst=1 during VALID: all outputs return to reset values on the next edge.
  - Separately, redirect_pc=32'hFFFF_FFFC: required ir_pc sequence FFFF_FFFC then 0000_0000, with imem_addr wrapping 8'hFF then 8'h00.
